// File: rtl/quad_step_decoder_pkg.sv
// Shared types and the step classifier for the quadrature step decoder.
package quad_pkg;

    typedef enum logic [1:0] {
        S00 = 2'b00,
        S01 = 2'b01,
        S11 = 2'b11,
        S10 = 2'b10
    } quad_state_t;

    typedef enum logic [1:0] {
        STEP_NONE,
        STEP_FWD,
        STEP_REV,
        STEP_ERR
    } step_t;

    // Forward order is 00->10->11->01->00 (A leads); a double-bit change is illegal.
    function automatic step_t quad_step(input quad_state_t prev, input quad_state_t next);
        quad_state_t fwd;
        step_t       s;
        case (prev)
            S00:     fwd = S10;
            S10:     fwd = S11;
            S11:     fwd = S01;
            default: fwd = S00;
        endcase
        if (next == prev)
            s = STEP_NONE;
        else if ((2'(prev) ^ 2'(next)) == 2'b11)
            s = STEP_ERR;
        else if (next == fwd)
            s = STEP_FWD;
        else
            s = STEP_REV;
        return s;
    endfunction

endpackage

// File: rtl/quad_step_decoder_filter.sv
// Synchronizer plus persistence filter for one asynchronous encoder phase.
module quad_glitch_filter
    import quad_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_LEN  = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic stable_c
);

    localparam int unsigned CNT_W  = $clog2(FILTER_LEN + 1);
    localparam int unsigned FILL_W = $clog2(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [CNT_W-1:0]       cnt;
    logic [FILL_W-1:0]      fill;
    logic                   synced;
    logic                   warm;

    assign synced = sync[SYNC_STAGES-1];
    assign warm   = (fill == FILL_W'(SYNC_STAGES));

    // Stable only once the chain holds post-reset samples that agree with the level.
    assign stable_c = warm && (cnt == '0) && (synced == level);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync  <= '0;
            cnt   <= '0;
            fill  <= '0;
            level <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], din};
            if (!warm)
                fill <= fill + FILL_W'(1);
            if (synced != level) begin
                if (cnt == CNT_W'(FILTER_LEN - 1)) begin
                    level <= ~level;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature decoder: filtered phases drive a Gray-code FSM producing step pulses,
// a sticky illegal-transition flag and a wrapping debug position.
module quad_step_decoder
    import quad_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_LEN  = 4,
    parameter int unsigned POS_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             phase_a,
    input  logic             phase_b,
    input  logic             enable,
    input  logic             err_clr,
    output logic             increment,
    output logic             decrement,
    output logic             error,
    output logic [POS_W-1:0] position
);

    logic        level_a;
    logic        level_b;
    logic        stable_a_c;
    logic        stable_b_c;
    logic        primed;
    quad_state_t state;
    quad_state_t levels_c;
    step_t       step_c;

    quad_glitch_filter #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILTER_LEN (FILTER_LEN)
    ) u_filt_a (
        .clk     (clk),
        .reset   (reset),
        .din     (phase_a),
        .level   (level_a),
        .stable_c(stable_a_c)
    );

    quad_glitch_filter #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILTER_LEN (FILTER_LEN)
    ) u_filt_b (
        .clk     (clk),
        .reset   (reset),
        .din     (phase_b),
        .level   (level_b),
        .stable_c(stable_b_c)
    );

    assign levels_c = quad_state_t'({level_a, level_b});
    assign step_c   = quad_step(state, levels_c);

    // FSM always tracks the filtered levels; enable only gates the visible effects.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S00;
            primed    <= 1'b0;
            increment <= 1'b0;
            decrement <= 1'b0;
            error     <= 1'b0;
            position  <= '0;
        end else begin
            increment <= 1'b0;
            decrement <= 1'b0;
            if (err_clr)
                error <= 1'b0;
            if (!primed) begin
                if (stable_a_c && stable_b_c) begin
                    state  <= levels_c;
                    primed <= 1'b1;
                end
            end else begin
                state <= levels_c;
                if (enable) begin
                    case (step_c)
                        STEP_FWD: begin
                            increment <= 1'b1;
                            position  <= position + POS_W'(1);
                        end
                        STEP_REV: begin
                            decrement <= 1'b1;
                            position  <= position - POS_W'(1);
                        end
                        STEP_ERR: error <= 1'b1;
                        default:  ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_quad_step_decoder.sv
// Scoreboard bench for quad_step_decoder: stimulus queues expected pulses, a negedge monitor checks them.
module tb_quad_step_decoder;
    import quad_pkg::*;

    localparam int unsigned LAT = 7;

    typedef struct {
        step_t kind;
        int    due;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       phase_a;
    logic       phase_b;
    logic       enable;
    logic       err_clr;
    logic       increment;
    logic       decrement;
    logic       error;
    logic [7:0] position;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t exp_q[$];

    quad_step_decoder #(
        .SYNC_STAGES(2),
        .FILTER_LEN (4),
        .POS_W      (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .phase_a  (phase_a),
        .phase_b  (phase_b),
        .enable   (enable),
        .err_clr  (err_clr),
        .increment(increment),
        .decrement(decrement),
        .error    (error),
        .position (position)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called just after a posedge; the next edge is the first to sample the new levels.
    task automatic drive(input logic a, input logic b, input step_t expk);
        exp_t e;
        phase_a = a;
        phase_b = b;
        if (expk == STEP_FWD || expk == STEP_REV) begin
            e.kind = expk;
            e.due  = cyc + LAT;
            exp_q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (increment === 1'b1 || decrement === 1'b1) begin
            check("pulse_exclusive", int'(increment & decrement), 0);
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", int'({decrement, increment}), 0);
            end else begin
                e = exp_q.pop_front();
                check("pulse_kind", increment ? 1 : 2, (e.kind == STEP_FWD) ? 1 : 2);
                check("pulse_cycle", cyc, e.due);
            end
        end
    end

    initial begin
        reset   = 1'b1;
        phase_a = 1'b1;
        phase_b = 1'b1;
        enable  = 1'b1;
        err_clr = 1'b0;

        // 1: prime to S11 with no activity
        tick(10);
        check("reset_position", int'(position), 0);
        check("reset_inc_dec", int'({increment, decrement}), 0);
        reset = 1'b0;
        tick(20);
        check("prime_state", int'(dut.state), 3);
        check("prime_primed", int'(dut.primed), 1);
        check("prime_error", int'(error), 0);
        check("prime_position", int'(position), 0);

        // 2: forward sweep from S00
        reset = 1'b1; phase_a = 1'b0; phase_b = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(20);
        check("prime00_state", int'(dut.state), 0);
        drive(1'b1, 1'b0, STEP_FWD); tick(8);
        drive(1'b1, 1'b1, STEP_FWD); tick(8);
        drive(1'b0, 1'b1, STEP_FWD); tick(8);
        drive(1'b0, 1'b0, STEP_FWD); tick(12);
        check("fwd_position", int'(position), 4);
        check("fwd_drained", exp_q.size(), 0);

        // 3: three reverse cycles wrap below zero
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(20);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, STEP_REV); tick(8);
            drive(1'b1, 1'b1, STEP_REV); tick(8);
            drive(1'b1, 1'b0, STEP_REV); tick(8);
            drive(1'b0, 1'b0, STEP_REV); tick(8);
        end
        tick(4);
        check("rev_position", int'(position), 244);

        // 4: 3-cycle glitch is rejected; 4-cycle pulse passes both ways
        drive(1'b1, 1'b0, STEP_NONE); tick(3);
        drive(1'b0, 1'b0, STEP_NONE); tick(15);
        check("glitch_state", int'(dut.state), 0);
        check("glitch_position", int'(position), 244);
        drive(1'b1, 1'b0, STEP_FWD); tick(4);
        drive(1'b0, 1'b0, STEP_REV); tick(15);
        check("bounce_position", int'(position), 244);

        // 5: illegal transition, clear, and clear losing to a coincident illegal step
        drive(1'b1, 1'b1, STEP_NONE); tick(15);
        check("illegal_error", int'(error), 1);
        check("illegal_position", int'(position), 244);
        check("illegal_state", int'(dut.state), 3);
        err_clr = 1'b1; tick(1); err_clr = 1'b0;
        check("err_clr", int'(error), 0);
        drive(1'b0, 1'b0, STEP_NONE);
        tick(6);
        err_clr = 1'b1; tick(1); err_clr = 1'b0;
        check("err_set_wins", int'(error), 1);
        tick(8);

        // 6: disabled step is tracked silently, then normal step, then reset mid-pulse
        enable = 1'b0;
        drive(1'b1, 1'b0, STEP_NONE); tick(12);
        enable = 1'b1;
        tick(12);
        check("disabled_position", int'(position), 244);
        check("disabled_state", int'(dut.state), 2);
        drive(1'b1, 1'b1, STEP_FWD); tick(12);
        check("reenable_position", int'(position), 245);
        drive(1'b0, 1'b1, STEP_NONE);
        tick(6);
        reset = 1'b1; tick(1);
        check("midreset_inc_dec", int'({increment, decrement}), 0);
        check("midreset_error", int'(error), 0);
        check("midreset_position", int'(position), 0);
        tick(2);
        reset = 1'b0;
        tick(5);

        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
